// File: rtl/smart_cargo_movimento_uc.sv
// Movement/stop sequencer for the smart cargo elevator.
// Drives motor, floor register loads, cargo strobes, door and queue shift.
module smart_cargo_movimento_uc #(
    parameter int TIMER_PORTA     = 100000000,
    parameter int TIMER_MOVIMENTO = 500000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       emergencia,
    input  logic       temDestino,
    input  logic       chegouDestino,
    input  logic       sobe,
    input  logic       eh_origem_fila,
    input  logic       bordaSensorAtivo,
    output logic       motor_sobe,
    output logic       motor_desce,
    output logic       inicializa_andar,
    output logic       enableAndarAtual,
    output logic       coloca_objetos,
    output logic       tira_objetos,
    output logic       shift,
    output logic       porta_aberta,
    output logic [3:0] db_estado
);

    localparam int TMAX = (TIMER_PORTA > TIMER_MOVIMENTO) ?
                          TIMER_PORTA : TIMER_MOVIMENTO;
    localparam int CW   = $clog2(TMAX);

    localparam logic [CW-1:0] FIM_PORTA = CW'(TIMER_PORTA - 1);
    localparam logic [CW-1:0] FIM_MOV   = CW'(TIMER_MOVIMENTO - 1);

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        INICIALIZA = 4'd1,
        OCIOSO     = 4'd2,
        MOVENDO    = 4'd3,
        ATUALIZA   = 4'd4,
        CHECA      = 4'd5,
        PARADA     = 4'd6,
        CARGA      = 4'd7,
        DESCARGA   = 4'd8,
        ESPERA     = 4'd9,
        AVANCA     = 4'd10,
        EMERGENCIA = 4'd15
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] contador;
    logic          dir;
    logic          em_movimento;

    // Sequencer: state, shared dwell/watchdog counter and travel direction.
    // The counter only runs in MOVENDO and ESPERA and is zero elsewhere,
    // so every entry into a counting state starts from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= INICIAL;
            contador <= '0;
            dir      <= 1'b0;
        end else if (emergencia && estado != INICIAL) begin
            estado   <= EMERGENCIA;
            contador <= '0;
        end else begin
            contador <= '0;
            case (estado)
                INICIAL: begin
                    if (iniciar) estado <= INICIALIZA;
                end
                INICIALIZA: estado <= OCIOSO;
                OCIOSO: begin
                    if (temDestino && chegouDestino) begin
                        estado <= PARADA;
                    end else if (temDestino) begin
                        estado <= MOVENDO;
                        dir    <= sobe;
                    end
                end
                MOVENDO: begin
                    if (bordaSensorAtivo) begin
                        estado <= ATUALIZA;
                    end else if (contador == FIM_MOV) begin
                        estado <= EMERGENCIA;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                ATUALIZA: estado <= CHECA;
                CHECA: begin
                    if (chegouDestino) begin
                        estado <= PARADA;
                    end else begin
                        estado <= MOVENDO;
                        dir    <= sobe;
                    end
                end
                PARADA: begin
                    if (eh_origem_fila) estado <= CARGA;
                    else                estado <= DESCARGA;
                end
                CARGA:    estado <= ESPERA;
                DESCARGA: estado <= ESPERA;
                ESPERA: begin
                    if (contador == FIM_PORTA) begin
                        estado <= AVANCA;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                AVANCA: estado <= OCIOSO;
                EMERGENCIA: begin
                    if (!emergencia && iniciar) estado <= INICIALIZA;
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    // Moore output decode from the state register and direction.
    assign em_movimento = (estado == MOVENDO) || (estado == ATUALIZA) ||
                          (estado == CHECA);

    assign motor_sobe       = em_movimento & dir;
    assign motor_desce      = em_movimento & ~dir;
    assign inicializa_andar = (estado == INICIALIZA);
    assign enableAndarAtual = (estado == ATUALIZA);
    assign coloca_objetos   = (estado == CARGA);
    assign tira_objetos     = (estado == DESCARGA);
    assign shift            = (estado == AVANCA);
    assign porta_aberta     = (estado == PARADA) || (estado == CARGA) ||
                              (estado == DESCARGA) || (estado == ESPERA);
    assign db_estado        = estado;

endmodule

// File: tb/tb_smart_cargo_movimento_uc.sv
// Bench for smart_cargo_movimento_uc: directed scenarios pinned by literal
// values, then randomized stimulus compared against a behavioural model.
module tb_smart_cargo_movimento_uc;

    localparam int TP = 4;
    localparam int TM = 20;

    logic clock = 1'b0;
    logic reset, iniciar, emergencia, temDestino, chegouDestino;
    logic sobe, eh_origem_fila, bordaSensorAtivo;
    logic motor_sobe, motor_desce, inicializa_andar, enableAndarAtual;
    logic coloca_objetos, tira_objetos, shift, porta_aberta;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase name by code, time spent in the current timed phase,
    // and remembered direction of travel.
    int m_phase = 0;
    int m_time  = 0;
    bit m_up    = 0;

    always #5 clock = ~clock;

    smart_cargo_movimento_uc #(
        .TIMER_PORTA    (TP),
        .TIMER_MOVIMENTO(TM)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .emergencia      (emergencia),
        .temDestino      (temDestino),
        .chegouDestino   (chegouDestino),
        .sobe            (sobe),
        .eh_origem_fila  (eh_origem_fila),
        .bordaSensorAtivo(bordaSensorAtivo),
        .motor_sobe      (motor_sobe),
        .motor_desce     (motor_desce),
        .inicializa_andar(inicializa_andar),
        .enableAndarAtual(enableAndarAtual),
        .coloca_objetos  (coloca_objetos),
        .tira_objetos    (tira_objetos),
        .shift           (shift),
        .porta_aberta    (porta_aberta),
        .db_estado       (db_estado)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Advance the model by one clock using the spec's transition rules.
    task automatic model_tick();
        if (reset) begin
            m_phase = 0; m_time = 0; m_up = 0;
        end else if (emergencia && m_phase != 0) begin
            m_phase = 15; m_time = 0;
        end else begin
            case (m_phase)
                0: if (iniciar) m_phase = 1;
                1: m_phase = 2;
                2: if (temDestino) begin
                    if (chegouDestino) m_phase = 6;
                    else begin m_phase = 3; m_up = sobe; m_time = 0; end
                end
                3: begin
                    m_time++;
                    if (bordaSensorAtivo) m_phase = 4;
                    else if (m_time >= TM) m_phase = 15;
                end
                4: m_phase = 5;
                5: if (chegouDestino) m_phase = 6;
                   else begin m_phase = 3; m_up = sobe; m_time = 0; end
                6: begin
                    m_phase = eh_origem_fila ? 7 : 8;
                    m_time = 0;
                end
                7, 8: begin m_phase = 9; m_time = 0; end
                9: begin
                    m_time++;
                    if (m_time >= TP) m_phase = 10;
                end
                10: m_phase = 2;
                15: if (!emergencia && iniciar) m_phase = 1;
                default: m_phase = 0;
            endcase
        end
    endtask

    function automatic logic [7:0] model_outs();
        bit moving;
        logic [7:0] v;
        moving = (m_phase >= 3 && m_phase <= 5);
        v[7] = moving && m_up;
        v[6] = moving && !m_up;
        v[5] = (m_phase == 1);
        v[4] = (m_phase == 4);
        v[3] = (m_phase == 7);
        v[2] = (m_phase == 8);
        v[1] = (m_phase == 10);
        v[0] = (m_phase >= 6 && m_phase <= 9);
        return v;
    endfunction

    task automatic compare();
        logic [7:0] act;
        act = {motor_sobe, motor_desce, inicializa_andar, enableAndarAtual,
               coloca_objetos, tira_objetos, shift, porta_aberta};
        chk("db_estado", int'(db_estado), m_phase);
        chk("outputs", int'(act), int'(model_outs()));
        chk("motor_excl", int'(motor_sobe & motor_desce), 0);
    endtask

    task automatic step();
        @(posedge clock);
        model_tick();
        @(negedge clock);
        compare();
    endtask

    task automatic idle_inputs();
        iniciar = 0; emergencia = 0; temDestino = 0; chegouDestino = 0;
        sobe = 0; eh_origem_fila = 0; bordaSensorAtivo = 0;
    endtask

    initial begin
        int door;
        reset = 1;
        idle_inputs();
        step();
        step();
        chk("reset_state", int'(db_estado), 0);
        chk("reset_porta", int'(porta_aberta), 0);
        reset = 0;

        // Start-up: 0 -> 1 -> 2
        iniciar = 1;
        step();
        chk("init_state", int'(db_estado), 1);
        chk("init_pulse", int'(inicializa_andar), 1);
        iniciar = 0;
        step();
        chk("ocioso", int'(db_estado), 2);
        chk("init_off", int'(inicializa_andar), 0);

        // Trip up, edge after 5 moving cycles, pickup
        temDestino = 1; sobe = 1; eh_origem_fila = 1;
        step();
        chk("mov_state", int'(db_estado), 3);
        chk("mov_up", int'(motor_sobe), 1);
        repeat (4) step();
        bordaSensorAtivo = 1;
        step();
        bordaSensorAtivo = 0; chegouDestino = 1;
        chk("atualiza", int'(db_estado), 4);
        chk("enable_andar", int'(enableAndarAtual), 1);
        step();
        chk("checa_up", int'(motor_sobe), 1);
        door = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (porta_aberta) door++;
        end
        chk("door_cycles", door, TP + 2);
        chk("back_idle", int'(db_estado), 2);

        // Watchdog: 20 moving cycles with no edge
        chegouDestino = 0; sobe = 0;
        step();
        repeat (TM - 1) step();
        chk("wd_still_moving", int'(db_estado), 3);
        chk("wd_down", int'(motor_desce), 1);
        step();
        chk("wd_emerg", int'(db_estado), 15);
        chk("wd_motor_off", int'(motor_desce | motor_sobe), 0);
        temDestino = 0; iniciar = 1;
        step();
        chk("emerg_restart", int'(db_estado), 1);
        iniciar = 0;
        step();

        // Emergency mid-ESPERA with iniciar held
        temDestino = 1; chegouDestino = 1; eh_origem_fila = 0;
        step();
        step();
        chk("descarga_pulse", int'(tira_objetos), 1);
        chk("descarga_no_col", int'(coloca_objetos), 0);
        temDestino = 0;
        step();
        step();
        chk("espera", int'(db_estado), 9);
        emergencia = 1; iniciar = 1;
        step();
        chk("emerg_state", int'(db_estado), 15);
        chk("emerg_door", int'(porta_aberta), 0);
        step();
        chk("emerg_hold", int'(db_estado), 15);
        emergencia = 0;
        step();
        chk("emerg_release", int'(db_estado), 1);
        iniciar = 0;
        step();

        // Reversal at CHECA
        temDestino = 1; chegouDestino = 0; sobe = 1;
        step();
        bordaSensorAtivo = 1;
        step();
        bordaSensorAtivo = 0; sobe = 0;
        step();
        step();
        chk("rev_state", int'(db_estado), 3);
        chk("rev_down", int'(motor_desce), 1);
        chk("rev_up_off", int'(motor_sobe), 0);

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            reset            = ($urandom_range(0, 299) == 0);
            emergencia       = ($urandom_range(0, 59) == 0);
            iniciar          = ($urandom_range(0, 3) == 0);
            temDestino       = ($urandom_range(0, 2) != 0);
            chegouDestino    = ($urandom_range(0, 2) == 0);
            sobe             = $urandom_range(0, 1);
            eh_origem_fila   = $urandom_range(0, 1);
            bordaSensorAtivo = ($urandom_range(0, 8) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
